// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - size encodings, FSM states and alignment helper for the data access unit
package mem_defs;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DONE      = 2'd2
  } dau_state_e;

  // Reserved size 3 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic mis;
    if (size == SZ_BYTE) begin
      mis = 1'b0;
    end else if (size == SZ_HALF) begin
      mis = addr[0];
    end else begin
      mis = (addr != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends a byte/half/word from a 32-bit read word
module load_align
  import mem_defs::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by low address bits, then sign- or zero-extend to 32 bits.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    if (size_i == SZ_BYTE) begin
      result_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
    end else if (size_i == SZ_HALF) begin
      result_o = {{16{sign_i & half_sel[15]}}, half_sel};
    end else begin
      result_o = rdata_i;
    end
  end

endmodule

// File: rtl/data_access_unit.sv
// rtl/data_access_unit.sv - M-stage load/store bus master with single outstanding transaction
module data_access_unit
  import mem_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        signedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  input  logic        stallW,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdataM,
  output logic        stall_mem,
  output logic        adelM,
  output logic        adesM
);

  dau_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        wr_q, wr_d;
  logic        discard_q, discard_d;

  logic        misaligned;
  logic        req_ok;
  logic        handshake;
  logic [31:0] wdata_rep;
  logic [31:0] aligned;

  assign misaligned = is_misaligned(sizeM, aluoutM[1:0]);
  assign req_ok     = (state_q == ST_IDLE) & memenM & ~flushM & ~misaligned;
  assign handshake  = req_ok & data_addr_ok;

  load_align u_load_align (
    .rdata_i  (rdata_q),
    .addr_i   (addr_q),
    .size_i   (size_q),
    .sign_i   (sign_q),
    .result_o (aligned)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; data_ok is only honoured once the address phase has completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (data_data_ok) state_d = (discard_q | flushM) ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (flushM | ~stallW) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction context: attributes latched at handshake, read data at data_ok, flush memory.
  always_comb begin
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sign_d    = sign_q;
    wr_d      = wr_q;
    discard_d = discard_q;
    if (handshake) begin
      addr_d    = aluoutM[1:0];
      size_d    = sizeM;
      sign_d    = signedM;
      wr_d      = memwriteM;
      discard_d = 1'b0;
    end
    if (state_q == ST_WAIT_DATA) begin
      if (data_data_ok) begin
        discard_d = 1'b0;
        if (!(discard_q | flushM)) rdata_d = wr_q ? 32'd0 : data_rdata;
      end else if (flushM) begin
        discard_d = 1'b1;
      end
    end
  end

  // Transaction context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= 32'd0;
      addr_q    <= 2'd0;
      size_q    <= 2'd0;
      sign_q    <= 1'b0;
      wr_q      <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      wr_q      <= wr_d;
      discard_q <= discard_d;
    end
  end

  // Store data lane replication.
  always_comb begin
    case (sizeM)
      SZ_BYTE: wdata_rep = {4{writedataM[7:0]}};
      SZ_HALF: wdata_rep = {2{writedataM[15:0]}};
      default: wdata_rep = writedataM;
    endcase
  end

  // Outputs; everything is forced low while reset is held.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    mem_rdataM = 32'd0;
    stall_mem  = 1'b0;
    adelM      = 1'b0;
    adesM      = 1'b0;
    if (!rst) begin
      data_req   = req_ok;
      data_wr    = memwriteM;
      data_size  = sizeM;
      data_addr  = aluoutM;
      data_wdata = wdata_rep;
      stall_mem  = req_ok | (state_q == ST_WAIT_DATA);
      adelM      = (state_q == ST_IDLE) & memenM & misaligned & ~memwriteM;
      adesM      = (state_q == ST_IDLE) & memenM & misaligned & memwriteM;
      mem_rdataM = (state_q == ST_DONE) ? aligned : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_access_unit.sv
// tb/tb_data_access_unit.sv - scoreboard bench for data_access_unit with random transactions
module tb_data_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, signedM, flushM, stallW;
  logic [1:0]  sizeM;
  logic [31:0] aluoutM, writedataM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_rdataM;
  logic        stall_mem, adelM, adesM;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];
  bit          pend = 1'b0;

  always #5 clk = ~clk;

  data_access_unit dut (
    .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .sizeM(sizeM),
    .signedM(signedM), .aluoutM(aluoutM), .writedataM(writedataM), .flushM(flushM),
    .stallW(stallW), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_rdataM(mem_rdataM),
    .stall_mem(stall_mem), .adelM(adelM), .adesM(adesM)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: alignment, store replication and load extraction by plain arithmetic.
  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 0) return 0;
    if (sz == 1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sg,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    if (sz >= 2) return rd;
    if (sz == 0) begin
      v = (rd >> (8 * (addr % 4))) % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    v = (rd >> (16 * ((addr / 2) % 2))) % 65536;
    if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {31'd0, data_req}, 0);
    check({tag, "_wr"}, {31'd0, data_wr}, 0);
    check({tag, "_size"}, {30'd0, data_size}, 0);
    check({tag, "_addr"}, data_addr, 0);
    check({tag, "_wdata"}, data_wdata, 0);
    check({tag, "_rdata"}, mem_rdataM, 0);
    check({tag, "_stall"}, {31'd0, stall_mem}, 0);
    check({tag, "_adel"}, {31'd0, adelM}, 0);
    check({tag, "_ades"}, {31'd0, adesM}, 0);
  endtask

  // Monitor: bus handshakes against the request queue, first cycle after data_ok against results.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (res_q.size() == 0) begin
          check("mon_res_unexpected", 1, 0);
        end else begin
          logic [31:0] e;
          e = res_q.pop_front();
          check("mon_rdataM", mem_rdataM, e);
          check("mon_stall_after", {31'd0, stall_mem}, 0);
        end
      end
      if (data_req && data_addr_ok) begin
        if (req_q.size() == 0) begin
          check("mon_req_unexpected", 1, 0);
        end else begin
          req_t r;
          r = req_q.pop_front();
          check("mon_addr", data_addr, r.addr);
          check("mon_wr", {31'd0, data_wr}, {31'd0, r.wr});
          check("mon_size", {30'd0, data_size}, {30'd0, r.size});
          check("mon_wdata", data_wdata, r.wdata);
        end
      end else if (data_data_ok && stall_mem && !data_req) begin
        pend = 1'b1;
      end
    end
  end

  task automatic run_txn(input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int adly, input int ddly, input bit flush_w, input int stw,
                         input bit viol);
    logic [31:0] exp;
    memenM = 1; memwriteM = wr; sizeM = sz; signedM = sg; aluoutM = addr; writedataM = wd;
    flushM = 0; stallW = 0; data_addr_ok = 0; data_data_ok = 0;
    if (m_mis(sz, addr)) begin
      @(negedge clk);
      check("mis_adel", {31'd0, adelM}, {31'd0, !wr});
      check("mis_ades", {31'd0, adesM}, {31'd0, wr});
      check("mis_req", {31'd0, data_req}, 0);
      check("mis_stall", {31'd0, stall_mem}, 0);
      tick();
      memenM = 0;
      return;
    end
    req_q.push_back({addr, wr, sz, m_wdata(sz, wd)});
    for (int i = 0; i < adly; i++) begin
      @(negedge clk);
      check("hold_req", {31'd0, data_req}, 1);
      check("hold_addr", data_addr, addr);
      check("hold_wdata", data_wdata, m_wdata(sz, wd));
      check("hold_size", {30'd0, data_size}, {30'd0, sz});
      check("hold_stall", {31'd0, stall_mem}, 1);
      tick();
    end
    data_addr_ok = 1; data_data_ok = viol; data_rdata = $urandom;
    @(negedge clk);
    check("hs_stall", {31'd0, stall_mem}, 1);
    tick();
    data_addr_ok = 0; data_data_ok = 0;
    if (flush_w) begin flushM = 1; memenM = 0; end
    for (int i = 0; i < ddly; i++) begin
      data_rdata = $urandom;
      @(negedge clk);
      check("wait_stall", {31'd0, stall_mem}, 1);
      check("wait_req", {31'd0, data_req}, 0);
      check("wait_rdata", mem_rdataM, 0);
      tick();
      flushM = 0;
    end
    data_data_ok = 1; data_rdata = rd;
    exp = (flush_w || wr) ? 32'd0 : m_load(sz, sg, addr, rd);
    res_q.push_back(exp);
    @(negedge clk);
    check("dok_stall", {31'd0, stall_mem}, 1);
    tick();
    data_data_ok = 0; flushM = 0; data_rdata = $urandom;
    if (flush_w) begin
      @(negedge clk);
      check("disc_stall", {31'd0, stall_mem}, 0);
      tick();
      return;
    end
    stallW = 1;
    for (int i = 0; i < stw; i++) begin
      @(negedge clk);
      check("done_hold", mem_rdataM, exp);
      check("done_req", {31'd0, data_req}, 0);
      check("done_stall", {31'd0, stall_mem}, 0);
      tick();
    end
    stallW = 0;
    @(negedge clk);
    check("done_last", mem_rdataM, exp);
    tick();
    memenM = 0;
    @(negedge clk);
    check("idle_rdata", mem_rdataM, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; memenM = 1; memwriteM = 0; sizeM = 2; signedM = 0; aluoutM = 32'h100;
    writedataM = 32'hDEAD_BEEF; flushM = 0; stallW = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    memenM = 0; rst = 0;
    tick();

    // lb signed from byte 3
    run_txn(0, 0, 1, 32'h1003, 0, 32'h80FF_FF7F, 0, 0, 0, 0, 0);
    // sh with address phase delayed
    run_txn(1, 1, 0, 32'h2002, 32'h1234_ABCD, 0, 3, 0, 0, 0, 0);
    // misaligned word load / store
    run_txn(0, 2, 0, 32'h3001, 0, 0, 0, 0, 0, 0, 0);
    run_txn(1, 2, 0, 32'h3002, 32'h55, 0, 0, 0, 0, 0, 0);
    // flush in WAIT_DATA, data_ok 4 cycles later
    run_txn(0, 2, 0, 32'h4000, 0, 32'hCAFE_F00D, 0, 4, 1, 0, 0);
    // lhu held in DONE by stallW
    run_txn(0, 1, 0, 32'h10, 0, 32'h0000_8001, 0, 0, 0, 3, 0);
    // data_ok alongside addr_ok must be ignored
    run_txn(0, 2, 0, 32'h20, 0, 32'h1357_9BDF, 0, 1, 0, 0, 1);

    // reset during WAIT_DATA
    memenM = 1; memwriteM = 0; sizeM = 2; signedM = 0; aluoutM = 32'h5000;
    req_q.push_back({32'h5000, 1'b0, 2'd2, writedataM});
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; rst = 1;
    @(negedge clk);
    check_all_zero("rst_mid");
    tick();
    rst = 0; memenM = 0;
    @(negedge clk);
    check("rst_idle_stall", {31'd0, stall_mem}, 0);
    check("rst_idle_rdata", mem_rdataM, 0);
    tick();

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = (sz == 0) ? a : (sz == 1) ? (a & ~32'h1) : (a & ~32'h3);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    tick();
    tick();
    check("req_q_empty", req_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_access_unit.md
DATA_ACCESS_UNIT -- requirements
Module: data_access_unit

Interface
REQ-001 The port list SHALL be, in order: name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 memenM  in  1  memory instruction present in M stage.
REQ-005 memwriteM  in  1  1 = store, 0 = load.
REQ-006 sizeM  in  2  0 = byte, 1 = half, 2 = word (3 reserved, treated as word).
REQ-007 signedM  in  1  load sign-extends when 1, zero-extends when 0.
REQ-008 aluoutM  in  32  effective address.
REQ-009 writedataM  in  32  store source register value.
REQ-010 flushM  in  1  exception/flush of M stage.
REQ-011 stallW  in  1  M/W pipeline register is stalled.
REQ-012 data_req, data_wr  out  1 each  bus request and write flag.
REQ-013 data_size  out  2; data_addr  out  32; data_wdata  out  32  bus request fields.
REQ-014 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32  bus responses.
REQ-015 mem_rdataM  out  32  aligned and extended load result to the M/W register.
REQ-016 stall_mem  out  1  stall request to the pipeline; adelM, adesM  out  1 each  load/store address error.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT_DATA, and DONE.
REQ-018 In IDLE, data_req SHALL be combinational: memenM & ~flushM & ~misaligned.
REQ-019 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 A misaligned load SHALL raise adelM, and a misaligned store SHALL raise adesM, in the same cycle with no bus request.
REQ-021 In IDLE, the FSM SHALL go to WAIT_DATA when data_req & data_addr_ok, and SHALL otherwise hold the request with all fields stable.
REQ-022 In WAIT_DATA, data_req SHALL be 0; on data_data_ok, load data SHALL be captured into a 32-bit register and the FSM SHALL go to DONE.
REQ-023 In DONE, there SHALL be no request and stall_mem SHALL be 0; the FSM SHALL go to IDLE when ~stallW, and otherwise hold the captured data.
REQ-024 stall_mem SHALL equal (IDLE & data_req) | WAIT_DATA.
REQ-025 Minimum latency SHALL be addr_ok in cycle 0, data_ok in cycle 1, and DONE in cycle 2; data_ok in the same cycle as addr_ok is a protocol violation and SHALL be ignored.
REQ-026 data_addr SHALL equal aluoutM.
REQ-027 data_wr SHALL equal memwriteM, and data_size SHALL equal sizeM.
REQ-028 data_wdata SHALL replicate the source value: byte gives {4{wd[7:0]}}, half gives {2{wd[15:0]}}, word gives wd.
REQ-029 Load extraction SHALL select the byte by addr[1:0], or the half by addr[1], then sign-/zero-extend per signedM; word passes through unchanged.
REQ-030 Extraction SHALL use the address latched at the addr_ok handshake.
REQ-031 mem_rdataM SHALL be the extracted captured data in DONE, and 0 otherwise.
REQ-032 flushM in IDLE SHALL suppress the request.
REQ-033 flushM in WAIT_DATA SHALL set a discard flag and keep stall_mem=1 until data_data_ok, then go to IDLE (not DONE) with no data delivered.
REQ-034 flushM in DONE SHALL return the FSM to IDLE.
REQ-035 Exactly one outstanding transaction SHALL exist at any time.

Reset
REQ-036 On rst=1 at posedge, the FSM SHALL go to IDLE and the captured data, latched address/size/signed, and discard flag SHALL be cleared.
REQ-037 While rst=1, all outputs SHALL be 0.
REQ-038 Reset mid-transaction SHALL abandon the transaction; the bus slave shares rst.

Structure
REQ-039 Package mem_defs SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding.
REQ-040 Sub-module load_align SHALL be combinational, taking (rdata, addr[1:0], size, signed) and producing the 32-bit result; it is reused by the writeback forwarding logic.

Verification
REQ-041 lb, addr=0x1003, signed, rdata=0x80FF_FF7F, addr_ok at t0, data_ok at t1 -> stall_mem=1 for 2 cycles, then mem_rdataM=0xFFFF_FF80.
REQ-042 sh, addr=0x2002, wd=0x1234_ABCD -> data_wdata=0xABCD_ABCD, data_size=1, data_wr=1; addr_ok withheld 3 cycles -> data_req and fields held stable.
REQ-043 lw, addr=0x3001 -> adelM=1, data_req=0, stall_mem=0; sw, addr=0x3002 -> adesM=1.
REQ-044 lw issued, flushM=1 in WAIT_DATA, data_ok 4 cycles later -> stall_mem=1 until data_ok, then IDLE with mem_rdataM=0.
REQ-045 lhu, addr=0x10, rdata=0x0000_8001, stallW=1 for 3 cycles in DONE -> mem_rdataM=0x0000_8001 held until stallW falls.
REQ-046 rst asserted in WAIT_DATA -> IDLE next cycle, with all outputs 0 while rst=1.
